fpu_addsub_scheduler: RTL and testbench
=======================================

# fpu_addsub_scheduler

Shared FP32 add/subtract engine with a round-robin front end. It sits between up to four requesters, such as the CPU FPU decode stage and neuron-update units, and a single multi-cycle add/sub datapath. The datapath performs alignment, addition, leading-one normalization and packing. One operation is in flight at a time, and the result is returned over a valid/ready handshake tagged with the requester ID.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, legal 2..4.

Ports (name, direction, width, meaning). Clock is `clk`; reset is `reset`, synchronous, active-high.
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: per-requester request.
- `req_ready`, out, NUM_REQ: one-hot grant/accept.
- `req_op`, in, NUM_REQ: per-requester op (0 = add, 1 = sub, A−B).
- `req_a`, in, 32·NUM_REQ: operand A, requester i at bits [32i+31:32i].
- `req_b`, in, 32·NUM_REQ: operand B, same packing.
- `resp_valid`, out, 1: result available.
- `resp_ready`, in, 1: consumer accepts result.
- `resp_result`, out, 32: FP32 result.
- `resp_id`, out, 2: index of the requester that issued the operation.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE → ALIGN → ADD → NORM → PACK → DONE → IDLE.
- **IDLE**
  - If any `req_valid` is high, grant exactly one requester by round-robin: search starts at last_grant+1 and wraps.
  - Assert that requester's `req_ready` combinationally in the same cycle.
  - Capture its op, A, B and id; update last_grant; go to ALIGN.
  - `req_ready` is all-zero in every other state.
- **ALIGN**
  - For sub, invert B's sign.
  - Order operands so X has the larger magnitude (exp, then mantissa).
  - Expand both to 24-bit mantissas with the implicit 1.
  - Right-shift Y's mantissa by expX−expY; a difference ≥ 25 gives 0.
  - Shifted-out bits are discarded: truncation rounding.
- **ADD**
  - Same signs: 25-bit sum. Otherwise: X−Y.
  - Result sign = X sign.
- **NORM**
  - Carry at bit 24: shift right 1, exp+1.
  - Otherwise: priority-encode the leading one in bits [23:0], shift left so it lands at bit 23, and subtract the shift count from the exponent.
  - A zero mantissa gives result +0.
- **PACK**
  - Exponent ≥ 255: ±infinity (0x7F800000 | sign).
  - Exponent ≤ 0: +0.
  - Otherwise pack {sign, exp[7:0], mant[22:0]}.
- **DONE**
  - Hold `resp_valid` high with stable `resp_result`/`resp_id` until `resp_ready`; return to IDLE on the handshake.
- **Input rules**
  - An input exponent of 0 (denormal or zero) is treated as zero.
  - An input exponent of 255 in either operand gives result 0x7FC00000 through the normal path and latency.
- **Exact cancellation:** X−Y = 0 returns +0x00000000.

## Timing

- **Reset values:** state IDLE; `req_ready`=0; `resp_valid`=0; `resp_result`=0; `resp_id`=0; `busy`=0; last_grant=NUM_REQ−1, so requester 0 wins first.
- **Latency:** accept in cycle T (`req_valid`&`req_ready`) gives `resp_valid` high in cycle T+5.
- **Throughput:** one op per 6 cycles with `resp_ready` tied high. IDLE always lasts at least one cycle between ops.
- **Back-pressure:** `resp_ready` low holds DONE indefinitely. Outputs stay stable and no grant is issued.
- **Simultaneous requests:** exactly one grant; the others wait. A requester that keeps `req_valid` high is granted within NUM_REQ operations.
- **Requester hold:** a requester must hold `req_valid` and its operands until granted. Dropping `req_valid` before grant is legal; the request is simply not served.
- **Reset mid-operation:** the next cycle is IDLE with all outputs at reset values. The in-flight op is discarded and no response is produced.

## Configuration

- **`FPU_SCHED_ZERO_BYPASS_EN` defined:**
  - If either captured operand has exponent 0 (and neither has exponent 255), the FSM goes IDLE → DONE directly, with `resp_valid` at T+1.
  - Bypass results equal the full-path results:
    - A+0 = A; A−0 = A.
    - 0+B = B; 0−B = B with its sign inverted.
    - 0±0 = +0.
- **Undefined:** every operation takes the full 5-cycle path.

## Test plan

- **Add, latency check:** req0 A=0x3F800000, B=0x3F800000, add → 0x40000000, id 0, `resp_valid` exactly 5 cycles after accept.
- **Sub with normalization and cancellation:**
  - A=0x3FC00000 − B=0x3FA00000 → 0x3E800000.
  - A=0x3F800000 − A → 0x00000000.
- **Arbitration:** req0 and req1 held valid continuously with `resp_ready`=1 → grants alternate 0,1,0,1. `resp_id` matches, and a result is accepted every 6 cycles.
- **Back-pressure:** `resp_ready` low for 3 cycles in DONE → result stable, `req_ready` stays 0, and the handshake completes on the 4th cycle.
- **Overflow/special:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x7F800000 + 0x3F800000 → 0x7FC00000.
- **Reset mid-op and bypass:**
  - Reset asserted in NORM → no response; the next req0 is served normally.
  - With `FPU_SCHED_ZERO_BYPASS_EN`, 0x00000000 − 0x40400000 → 0xC0400000 at T+1. Without it, the same result arrives at T+5.

Source files
------------

// File: rtl/fpu_addsub_scheduler_if.sv
// ---------------------------------------------------------------------------
// fpu_addsub_scheduler_if
// Request/response bundle between up to four requesters and the shared FP32
// add/sub engine.
//   req_valid/req_ready : per-requester request, one-hot accept
//   req_op              : per-requester op (0 = add, 1 = sub A-B)
//   req_a/req_b         : packed operands, requester i at [32i+31:32i]
//   resp_valid/ready    : result handshake
//   resp_result/resp_id : FP32 result and issuing requester index
// master = requester/consumer side, slave = engine side.
// ---------------------------------------------------------------------------
interface fpu_addsub_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_result;
    logic [1:0]            resp_id;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_id
    );
endinterface

// File: rtl/fpu_addsub_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_addsub_scheduler
// Round-robin front end feeding a single multi-cycle FP32 add/sub datapath
// (IDLE -> ALIGN -> ADD -> NORM -> PACK -> DONE). One op in flight at a time;
// truncation rounding, denormal inputs flushed to zero, exp 255 -> 0x7FC00000.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : fpu_addsub_scheduler_if.slave (requests in, tagged result out)
//   busy  : high whenever the FSM is not in IDLE
// Optional feature: define FPU_SCHED_ZERO_BYPASS_EN to answer operations with
// a zero operand straight from IDLE (result valid one cycle after accept).
// ---------------------------------------------------------------------------
module fpu_addsub_scheduler #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fpu_addsub_scheduler_if.slave  bus,
    output logic                   busy
);
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [31:0] a_arr [NUM_REQ];
    logic [31:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[32*gi +: 32];
            assign b_arr[gi] = bus.req_b[32*gi +: 32];
        end
    endgenerate

    // ---------------- round-robin arbiter ----------------
    logic [1:0]         last_grant_reg;
    logic               grant_found;
    logic [1:0]         grant_idx;
    logic [NUM_REQ-1:0] grant_vec;
    logic [31:0]        a_sel, b_sel;
    logic               op_sel;

    // Walk offsets from farthest to nearest so the nearest valid requester
    // after last_grant is the final (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        a_sel       = '0;
        b_sel       = '0;
        op_sel      = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] &&
                    ((int'(last_grant_reg) + k == i) ||
                     (int'(last_grant_reg) + k - NUM_REQ == i))) begin
                    grant_found  = 1'b1;
                    grant_idx    = 2'(i);
                    grant_vec    = '0;
                    grant_vec[i] = 1'b1;
                    a_sel        = a_arr[i];
                    b_sel        = b_arr[i];
                    op_sel       = bus.req_op[i];
                end
            end
        end
    end

    // ---------------- zero bypass decision ----------------
    logic byp_take;
`ifdef FPU_SCHED_ZERO_BYPASS_EN
    logic [31:0] byp_result;
    always_comb begin
        byp_take = (a_sel[30:23] == 8'd0 || b_sel[30:23] == 8'd0) &&
                   a_sel[30:23] != 8'hFF && b_sel[30:23] != 8'hFF;
        if (a_sel[30:23] == 8'd0 && b_sel[30:23] == 8'd0)
            byp_result = 32'h0000_0000;
        else if (b_sel[30:23] == 8'd0)
            byp_result = a_sel;
        else
            byp_result = {b_sel[31] ^ op_sel, b_sel[30:0]};
    end
`else
    assign byp_take = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant_found) state_next = byp_take ? S_DONE : S_ALIGN;
            S_ALIGN: state_next = S_ADD;
            S_ADD:   state_next = S_NORM;
            S_NORM:  state_next = S_PACK;
            S_PACK:  state_next = S_DONE;
            S_DONE:  if (bus.resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_reg == S_IDLE && !reset) ? grant_vec : '0;
        bus.resp_valid = (state_reg == S_DONE);
        busy           = (state_reg != S_IDLE);
    end

    // ---------------- datapath ----------------
    logic [31:0]        a_reg, b_reg, result_reg;
    logic               op_reg;
    logic [1:0]         id_reg;
    logic               sign_x_reg, eff_sub_reg, nan_reg, zero_reg;
    logic signed [9:0]  exp_reg;
    logic [23:0]        mant_x_reg, mant_y_reg, mant_n_reg;
    logic [24:0]        sum_reg;

    // ALIGN: order by magnitude, restore implicit one, shift the smaller.
    logic [31:0] b_eff, x_op, y_op;
    logic [22:0] fa, fb;
    logic [23:0] mant_x_c, mant_y_c;
    logic [7:0]  exp_diff;
    always_comb begin
        b_eff    = {b_reg[31] ^ op_reg, b_reg[30:0]};
        fa       = (a_reg[30:23] == 8'd0) ? 23'd0 : a_reg[22:0];
        fb       = (b_reg[30:23] == 8'd0) ? 23'd0 : b_reg[22:0];
        if ({a_reg[30:23], fa} >= {b_reg[30:23], fb}) begin
            x_op = a_reg;
            y_op = b_eff;
        end else begin
            x_op = b_eff;
            y_op = a_reg;
        end
        mant_x_c = (x_op[30:23] == 8'd0) ? 24'd0 : {1'b1, x_op[22:0]};
        mant_y_c = (y_op[30:23] == 8'd0) ? 24'd0 : {1'b1, y_op[22:0]};
        exp_diff = x_op[30:23] - y_op[30:23];
        if (exp_diff >= 8'd25) mant_y_c = 24'd0;
        else                   mant_y_c = mant_y_c >> exp_diff;
    end

    // NORM: leading-one detect on the 25-bit sum.
    logic [4:0]        lead_pos;
    logic [4:0]        shift_amt;
    logic [23:0]       mant_n_c;
    logic signed [9:0] exp_n_c;
    logic              zero_c;
    always_comb begin
        lead_pos = 5'd0;
        for (int i = 0; i < 24; i++)
            if (sum_reg[i]) lead_pos = 5'(i);
        shift_amt = 5'd23 - lead_pos;
        zero_c    = 1'b0;
        if (sum_reg[24]) begin
            mant_n_c = sum_reg[24:1];
            exp_n_c  = exp_reg + 10'sd1;
        end else if (sum_reg[23:0] == 24'd0) begin
            mant_n_c = 24'd0;
            exp_n_c  = exp_reg;
            zero_c   = 1'b1;
        end else begin
            mant_n_c = sum_reg[23:0] << shift_amt;
            exp_n_c  = exp_reg - signed'(10'(shift_amt));
        end
    end

    // PACK
    logic [31:0] pack_c;
    always_comb begin
        if (nan_reg)                   pack_c = 32'h7FC0_0000;
        else if (zero_reg)             pack_c = 32'h0000_0000;
        else if (exp_reg >= 10'sd255)  pack_c = {sign_x_reg, 8'hFF, 23'd0};
        else if (exp_reg <= 10'sd0)    pack_c = 32'h0000_0000;
        else                           pack_c = {sign_x_reg, exp_reg[7:0], mant_n_reg[22:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 2'(NUM_REQ - 1);
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= 1'b0;
            id_reg         <= '0;
            result_reg     <= '0;
            sign_x_reg     <= 1'b0;
            eff_sub_reg    <= 1'b0;
            nan_reg        <= 1'b0;
            zero_reg       <= 1'b0;
            exp_reg        <= '0;
            mant_x_reg     <= '0;
            mant_y_reg     <= '0;
            mant_n_reg     <= '0;
            sum_reg        <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (grant_found) begin
                    last_grant_reg <= grant_idx;
                    id_reg         <= grant_idx;
                    a_reg          <= a_sel;
                    b_reg          <= b_sel;
                    op_reg         <= op_sel;
`ifdef FPU_SCHED_ZERO_BYPASS_EN
                    if (byp_take) result_reg <= byp_result;
`endif
                end
                S_ALIGN: begin
                    sign_x_reg  <= x_op[31];
                    eff_sub_reg <= x_op[31] ^ y_op[31];
                    nan_reg     <= (a_reg[30:23] == 8'hFF) || (b_reg[30:23] == 8'hFF);
                    exp_reg     <= signed'({2'b00, x_op[30:23]});
                    mant_x_reg  <= mant_x_c;
                    mant_y_reg  <= mant_y_c;
                end
                S_ADD: begin
                    sum_reg <= eff_sub_reg ? ({1'b0, mant_x_reg} - {1'b0, mant_y_reg})
                                           : ({1'b0, mant_x_reg} + {1'b0, mant_y_reg});
                end
                S_NORM: begin
                    mant_n_reg <= mant_n_c;
                    exp_reg    <= exp_n_c;
                    zero_reg   <= zero_c;
                end
                S_PACK:  result_reg <= pack_c;
                default: ;
            endcase
        end
    end

    assign bus.resp_result = result_reg;
    assign bus.resp_id     = id_reg;
endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
module tb_fpu_addsub_scheduler;
    localparam int N = 2;
`ifdef FPU_SCHED_ZERO_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = 5;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    fpu_addsub_scheduler_if #(.NUM_REQ(N)) bus ();

    fpu_addsub_scheduler #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic wait_grant(input int id, output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.req_ready[id]) break;
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid) break;
        end
    endtask

    task automatic do_op(input int id, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat, input string tag);
        int n;
        bus.req_op[id]         = op;
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
        bus.req_valid[id]      = 1'b1;
        wait_grant(id, n);
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << id));
        @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
        wait_resp(n);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_result"}, bus.resp_result, expv);
        chk({tag, "_id"}, 32'(bus.resp_id), 32'(id));
        $display("txn %s id=%0d op=%0d a=%h b=%h result=%h latency=%0d",
                 tag, id, op, a, b, bus.resp_result, n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int last_t;
        int expg;
        int hits;

        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_result", bus.resp_result, 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Arithmetic cases through the full path
        do_op(0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 5, "add_1p1");
        do_op(0, 1'b1, 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 5, "sub_norm");
        do_op(0, 1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 5, "cancel");
        do_op(0, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, "overflow");
        do_op(0, 1'b0, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 5, "special");
        do_op(0, 1'b1, 32'h00000000, 32'h40400000, 32'hC0400000, BYP_LAT, "zero_sub");

        // Back-pressure: hold DONE for 3 cycles while req1 waits
        bus.resp_ready  = 1'b0;
        bus.req_op[0]   = 1'b1;
        bus.req_a[31:0] = 32'h3FC00000;
        bus.req_b[31:0] = 32'h3FA00000;
        bus.req_valid[0] = 1'b1;
        wait_grant(0, n);
        chk("bp_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        bus.req_op[1]    = 1'b0;
        bus.req_a[63:32] = 32'h40000000;
        bus.req_b[63:32] = 32'h40000000;
        bus.req_valid[1] = 1'b1;
        wait_resp(n);
        chk("bp_latency", 32'(n), 32'd5);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_hold_result", bus.resp_result, 32'h3E800000);
            chk("bp_hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        chk("bp_4th_valid", 32'(bus.resp_valid), 32'd1);
        $display("txn bp id=0 result=%h held 3 cycles", bus.resp_result);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", 32'(bus.resp_valid), 32'd0);
        chk("bp_next_grant", 32'(bus.req_ready), 32'd2);
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        wait_resp(n);
        chk("bp_req1_latency", 32'(n), 32'd5);
        chk("bp_req1_result", bus.resp_result, 32'h40800000);
        chk("bp_req1_id", 32'(bus.resp_id), 32'd1);
        $display("txn bp_req1 id=1 result=%h latency=%0d", bus.resp_result, n);
        @(posedge clk);
        #1;

        // Reset asserted while the op is in NORM
        bus.req_op[0]    = 1'b0;
        bus.req_a[31:0]  = 32'h3F800000;
        bus.req_b[31:0]  = 32'h3F800000;
        bus.req_valid[0] = 1'b1;
        wait_grant(0, n);
        chk("rmo_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk);                 // ALIGN
        #1 bus.req_valid[0] = 1'b0;
        @(posedge clk);                 // ADD
        @(posedge clk);                 // NORM
        @(negedge clk);
        chk("rmo_busy_norm", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rmo_busy", 32'(busy), 32'd0);
        chk("rmo_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rmo_resp_result", bus.resp_result, 32'd0);
        chk("rmo_resp_id", 32'(bus.resp_id), 32'd0);
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) hits++;
        end
        chk("rmo_no_response", 32'(hits), 32'd0);
        $display("txn reset_mid_op discarded");
        @(posedge clk);
        #1;
        do_op(0, 1'b0, 32'h40000000, 32'h3F800000, 32'h40400000, 5, "after_reset");

        // Arbitration from a fresh reset: both requesters held valid
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.req_op       = '0;
        bus.req_a        = {32'h40000000, 32'h3F800000};
        bus.req_b        = {32'h3F800000, 32'h3F800000};
        bus.req_valid    = 2'b11;
        last_t = 0;
        for (int k = 0; k < 4; k++) begin
            expg = k % 2;
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                n++;
                if (bus.req_ready != '0) break;
            end
            chk("arb_grant", 32'(bus.req_ready), 32'(1 << expg));
            if (k > 0) chk("arb_spacing", 32'(cyc - last_t), 32'd6);
            last_t = cyc;
            wait_resp(n);
            chk("arb_latency", 32'(n), 32'd5);
            chk("arb_id", 32'(bus.resp_id), 32'(expg));
            chk("arb_result", bus.resp_result, (expg == 1) ? 32'h40400000 : 32'h40000000);
            $display("txn arb k=%0d id=%0d result=%h", k, bus.resp_id, bus.resp_result);
            if (k == 3) bus.req_valid = 2'b00;
        end
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
